// File: rtl/bsg_cell_accum_pkg.sv
// Shared types and widths for the bsg_cell_accum ring-word consumer stage.
// Input word: {op, operand}; result word: {carry, zero, acc}.
package bsg_cell_accum_pkg;

    localparam int unsigned BSG_CELL_ACCUM_WIDTH     = 10;
    localparam int unsigned BSG_CELL_ACCUM_ACC_WIDTH = BSG_CELL_ACCUM_WIDTH - 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_XOR  = 2'b10,
        OP_EMIT = 2'b11
    } bsg_cell_accum_op_e;

    typedef struct packed {
        bsg_cell_accum_op_e                    op;
        logic [BSG_CELL_ACCUM_ACC_WIDTH-1:0]   operand;
    } bsg_cell_accum_in_s;

    typedef struct packed {
        logic                                  carry;
        logic                                  zero;
        logic [BSG_CELL_ACCUM_ACC_WIDTH-1:0]   acc;
    } bsg_cell_accum_out_s;

    function automatic bsg_cell_accum_out_s pack_result(
        input logic                                carry,
        input logic [BSG_CELL_ACCUM_ACC_WIDTH-1:0] acc
    );
        bsg_cell_accum_out_s r;
        r.carry = carry;
        r.zero  = (acc == '0);
        r.acc   = acc;
        return r;
    endfunction

endpackage

// File: rtl/bsg_cell_accum_if.sv
// Stream bundle for bsg_cell_accum: valid/ready word input and valid/yumi result output.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface bsg_cell_accum_if
    import bsg_cell_accum_pkg::*;
#(
    parameter int width_p = BSG_CELL_ACCUM_WIDTH
);
    logic [width_p-1:0] data_i;
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               yumi_i;

    modport slave  (input  data_i, v_i, yumi_i, output ready_o, data_o, v_o);
    modport master (output data_i, v_i, yumi_i, input  ready_o, data_o, v_o);
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, ready-then-valid input, valid/yumi output. ready_o is registered so it
// has no path from yumi_i and is held low through reset; data_o reads zero when empty.
module bsg_two_fifo #(
    parameter int width_p = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [1:0]         count_reg;
    logic [1:0]         count_next;
    logic               rptr_reg;
    logic               wptr_reg;
    logic               ready_reg;
    logic               push;
    logic               pop;
    logic [width_p-1:0] head;

    assign push = v_i & ready_reg;
    assign pop  = yumi_i & (count_reg != 2'd0);

    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [width_p-1:0] entry_reg;
            always_ff @(posedge clk_i) begin
                if (push && (wptr_reg == 1'(gi))) begin
                    entry_reg <= data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_reg <= 2'd0;
            rptr_reg  <= 1'b0;
            wptr_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            ready_reg <= (count_next != 2'd2);
            if (push) wptr_reg <= ~wptr_reg;
            if (pop)  rptr_reg <= ~rptr_reg;
        end
    end

    assign head    = rptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign v_o     = (count_reg != 2'd0);
    assign data_o  = v_o ? head : '0;
    assign ready_o = ready_reg;

endmodule

// File: rtl/bsg_cell_accum.sv
// Opcode decode plus acc/carry registers; EMIT results queue in a two-entry output FIFO.
// Build option BSG_CELL_ACCUM_SAT_EN: ADD saturates at all-ones instead of wrapping.
module bsg_cell_accum
    import bsg_cell_accum_pkg::*;
#(
    parameter int width_p     = BSG_CELL_ACCUM_WIDTH,
    parameter int acc_width_p = BSG_CELL_ACCUM_ACC_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    bsg_cell_accum_if.slave  io
);
    generate
        if (width_p != 10 || acc_width_p != width_p - 2) begin : g_bad_width
            $error("bsg_cell_accum: width_p must be 10 and acc_width_p must be width_p-2");
        end
    endgenerate

    logic [acc_width_p-1:0] acc_reg;
    logic [acc_width_p-1:0] acc_next;
    logic                   carry_reg;
    logic                   carry_next;
    logic [acc_width_p:0]   sum;
    logic                   accept;
    logic                   emit;
    logic                   fifo_ready;
    logic                   fifo_v;
    logic [width_p-1:0]     fifo_data;
    bsg_cell_accum_in_s     word;
    bsg_cell_accum_out_s    result;

    assign word   = io.data_i;
    assign accept = io.v_i & fifo_ready;
    assign emit   = accept & (word.op == OP_EMIT);
    assign sum    = {1'b0, acc_reg} + {1'b0, word.operand};

    // EMIT reports the pre-update state; acc/carry only change on the clock edge.
    assign result = pack_result(carry_reg, acc_reg);

    always_comb begin
        acc_next   = acc_reg;
        carry_next = carry_reg;
        if (accept) begin
            case (word.op)
                OP_LOAD: begin
                    acc_next   = word.operand;
                    carry_next = 1'b0;
                end
                OP_ADD: begin
`ifdef BSG_CELL_ACCUM_SAT_EN
                    acc_next   = sum[acc_width_p] ? '1 : sum[acc_width_p-1:0];
`else
                    acc_next   = sum[acc_width_p-1:0];
`endif
                    carry_next = carry_reg | sum[acc_width_p];
                end
                OP_XOR: begin
                    acc_next   = acc_reg ^ word.operand;
                end
                default: begin
                    acc_next   = acc_reg;
                    carry_next = carry_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
        end
    end

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_out_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ready_o   (fifo_ready),
        .data_i    (result),
        .v_i       (emit),
        .v_o       (fifo_v),
        .data_o    (fifo_data),
        .yumi_i    (io.yumi_i)
    );

    assign io.ready_o = fifo_ready;
    assign io.v_o     = fifo_v;
    assign io.data_o  = fifo_data;

endmodule

// File: tb/tb_bsg_cell_accum.sv
// Self-checking bench for bsg_cell_accum: directed literal sequences plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_bsg_cell_accum;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int errors = 0;
    int checks = 0;

    bsg_cell_accum_if #(.width_p(10)) io ();

    bsg_cell_accum dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (io.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: accumulator value, sticky carry, FIFO of pending results.
    logic [7:0] m_acc   = 8'h00;
    bit         m_carry = 1'b0;
    bit         m_live  = 1'b0;
    logic [9:0] m_q[$];
    bit         m_take;
    int         m_sum;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout want event at %0t", name, $time);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_acc   = 8'h00;
                m_carry = 1'b0;
                m_live  = 1'b0;
                m_q.delete();
            end else begin
                m_take = io.v_i && m_live && (m_q.size() < 2);
                if (io.yumi_i && m_q.size() > 0) void'(m_q.pop_front());
                if (m_take) begin
                    case (io.data_i[9:8])
                        2'b00: begin m_acc = io.data_i[7:0]; m_carry = 1'b0; end
                        2'b01: begin
                            m_sum = int'(m_acc) + int'(io.data_i[7:0]);
                            if (m_sum > 255) m_carry = 1'b1;
`ifdef BSG_CELL_ACCUM_SAT_EN
                            m_acc = (m_sum > 255) ? 8'hFF : 8'(m_sum);
`else
                            m_acc = 8'(m_sum % 256);
`endif
                        end
                        2'b10: m_acc = m_acc ^ io.data_i[7:0];
                        default: m_q.push_back({m_carry, (m_acc == 8'h00), m_acc});
                    endcase
                end
                m_live = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("ready_o", io.ready_o, m_live && (m_q.size() < 2));
            chk("v_o", io.v_o, m_q.size() > 0);
            if (m_q.size() > 0) chk("data_o", io.data_o, m_q[0]);
            else if (!reset_n)  chk("rst_data_o", io.data_o, 0);
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic send(input logic [9:0] w, input string name);
        int  n = 0;
        bit  rdy = 1'b0;
        io.data_i = w;
        io.v_i    = 1'b1;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = m_live && (m_q.size() < 2);
            @(posedge clk);
            #1;
            n++;
        end
        io.v_i = 1'b0;
        if (!rdy) fail_timeout({name, "_send"});
    endtask

    task automatic expect_out(input logic [9:0] exp, input string name);
        int n = 0;
        @(negedge clk);
        while (!io.v_o && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!io.v_o) begin
            fail_timeout({name, "_v_o"});
        end else begin
            chk(name, io.data_o, exp);
            if (m_q.size() > 0) chk({"model_", name}, m_q[0], exp);
            else fail_timeout({"model_", name});
            io.yumi_i = 1'b1;
        end
        @(posedge clk);
        #1;
        io.yumi_i = 1'b0;
    endtask

    initial begin
        logic [9:0] w;
        io.data_i = '0;
        io.v_i    = 1'b0;
        io.yumi_i = 1'b0;

        // Reset held for 5 cycles, with a word offered that must be ignored
        io.v_i    = 1'b1;
        io.data_i = 10'h0AB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_v_o", io.v_o, 0);
            chk("rst_ready_o", io.ready_o, 0);
            chk("rst_data", io.data_o, 0);
        end
        io.v_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", io.ready_o, 1);
        $display("reset released, ready_o=%0b", io.ready_o);

        send(10'h300, "emit0");
        expect_out(10'h100, "emit_after_reset");
        $display("txn emit after reset -> %h", 10'h100);

        send(10'h012, "load12");
        send(10'h134, "add34");
        send(10'h20F, "xor0f");
        send(10'h300, "emit1");
        expect_out(10'h049, "arith");
        $display("txn LOAD12 ADD34 XOR0F EMIT -> expected %h", 10'h049);

        send(10'h0F0, "loadf0");
        send(10'h120, "add20");
        send(10'h300, "emit2");
`ifdef BSG_CELL_ACCUM_SAT_EN
        expect_out(10'h2FF, "overflow_sat");
`else
        expect_out(10'h210, "overflow_wrap");
`endif
        send(10'h000, "load00");
        send(10'h300, "emit3");
        expect_out(10'h100, "carry_clear");
        $display("txn overflow then LOAD00 EMIT -> expected %h", 10'h100);

        // Backpressure: three back-to-back EMITs with the consumer stalled
        send(10'h07F, "load7f");
        io.data_i = 10'h300;
        io.v_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", io.ready_o, (i < 2) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        io.yumi_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_pop_cycle", io.ready_o, 0);
        @(posedge clk);
        #1;
        io.yumi_i = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_pop", io.ready_o, 1);
        @(posedge clk);
        #1;
        io.v_i = 1'b0;
        expect_out(10'h07F, "bp_out1");
        expect_out(10'h07F, "bp_out2");
        $display("txn backpressure drained, pending model entries=%0d", m_q.size());
        @(negedge clk);
        chk("bp_drained_v_o", io.v_o, 0);
        @(posedge clk);
        #1;

        // Mid-stream reset with two results queued
        send(10'h055, "load55");
        send(10'h300, "emit_q1");
        send(10'h300, "emit_q2");
        chk("mid_pre_v_o", io.v_o, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_v_o_drop", io.v_o, 0);
        chk("mid_data_zero", io.data_o, 0);
        chk("mid_ready_low", io.ready_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_no_stale", io.v_o, 0);
        send(10'h300, "emit_post");
        expect_out(10'h100, "mid_post_reset");
        $display("txn mid-stream reset -> post-reset emit %h", 10'h100);

        // Randomised traffic; the per-cycle compare process does the checking
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                io.v_i    = 1'b0;
                io.yumi_i = 1'b0;
                reset_n   = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
            w = 10'($urandom);
            if ($urandom_range(0, 3) == 0) w[7:4] = 4'hF;
            io.data_i = w;
            io.v_i    = ($urandom_range(0, 3) != 0);
            io.yumi_i = (m_q.size() > 0) && ((n % 200) >= 30) && ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        io.v_i    = 1'b0;
        io.yumi_i = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
